// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch PC sequencer with branch/stall/halt arbitration and debug run control
module fetch_sequencer #(
    parameter int         PC_WIDTH     = 10,
    parameter int         FLUSH_CYCLES = 1,
    parameter logic [5:0] HALT_OPCODE  = 6'b111111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                run_mode,
    input  logic                step,
    input  logic [31:0]         instruction,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                if_valid,
    output logic                flush,
    output logic                halted,
    output logic [15:0]         cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, HALT} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [2:0]          r_flush_cnt, w_flush_cnt_nxt;
    logic                r_step_pending, w_step_pending_nxt;
    logic                r_if_valid, w_if_valid_nxt;
    logic                r_flush, w_flush_nxt;
    logic                r_halted, w_halted_nxt;
    logic [15:0]         r_cycle_count, w_cycle_count_nxt;
    logic [5:0]          w_opcode;
    logic                w_advance;
    logic                w_consume;
    logic                w_step_req;

    assign w_opcode   = instruction[31:26];
    assign w_step_req = (r_state == STEP_WAIT) && step;
    assign w_advance  = (r_state == RUN) || ((r_state == STEP_WAIT) && r_step_pending);
    // A taken branch overrides a stall, so only a bare stall leaves the step pending
    assign w_consume  = branch_taken || !stall;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_pc           <= '0;
            r_flush_cnt    <= '0;
            r_step_pending <= 1'b0;
            r_if_valid     <= 1'b0;
            r_flush        <= 1'b0;
            r_halted       <= 1'b0;
            r_cycle_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_flush_cnt    <= w_flush_cnt_nxt;
            r_step_pending <= w_step_pending_nxt;
            r_if_valid     <= w_if_valid_nxt;
            r_flush        <= w_flush_nxt;
            r_halted       <= w_halted_nxt;
            r_cycle_count  <= w_cycle_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_flush_cnt_nxt    = r_flush_cnt;
        w_step_pending_nxt = r_step_pending;
        w_halted_nxt       = r_halted;
        w_cycle_count_nxt  = r_cycle_count;
        w_if_valid_nxt     = 1'b0;

        if (start) begin
            w_state_nxt        = run_mode ? STEP_WAIT : RUN;
            w_pc_nxt           = '0;
            w_flush_cnt_nxt    = '0;
            w_step_pending_nxt = 1'b0;
            w_halted_nxt       = 1'b0;
            w_cycle_count_nxt  = '0;
        end else if (w_advance) begin
            if (r_cycle_count != 16'hFFFF) begin
                w_cycle_count_nxt = r_cycle_count + 16'd1;
            end
            if (r_flush_cnt != 3'd0) begin
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            end
            w_step_pending_nxt = w_consume ? w_step_req : (r_step_pending | w_step_req);

            if (branch_taken) begin
                w_pc_nxt        = r_pc + branch_offset;
                w_flush_cnt_nxt = FLUSH_LOAD;
            end else if (stall) begin
                w_pc_nxt = r_pc;
            end else if (w_opcode == HALT_OPCODE) begin
                w_state_nxt  = HALT;
                w_halted_nxt = 1'b1;
            end else if ((w_opcode == OP_J) || (w_opcode == OP_JAL)) begin
                w_pc_nxt = instruction[PC_WIDTH-1:0];
            end else begin
                w_pc_nxt = r_pc + PC_WIDTH'(1);
            end

            w_if_valid_nxt = w_consume && (w_state_nxt != HALT) && (w_flush_cnt_nxt == 3'd0);
        end else if (w_step_req) begin
            w_step_pending_nxt = 1'b1;
        end

        w_flush_nxt = (w_flush_cnt_nxt != 3'd0);
    end

    assign pc          = r_pc;
    assign if_valid    = r_if_valid;
    assign flush       = r_flush;
    assign halted      = r_halted;
    assign cycle_count = r_cycle_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the instruction-fetch PC for the 10-bit-addressed instruction ROM.
- Arbitrates next-PC sources: branch, hazard stall, halt, jump and increment.
- Generates IF/ID valid and flush qualifiers.
- Adds start / halt / single-step run control for the debug unit.
- Sits between the hazard/branch logic in ID/EX and the ROM address input; replaces ad-hoc PC update logic in the fetch stage.

Parameters:
- PC_WIDTH, 10, PC and ROM address width; all PC arithmetic is modulo 2^PC_WIDTH.
- FLUSH_CYCLES, 1, number of fetch cycles killed after a taken branch (1..7).
- HALT_OPCODE, 6'b111111, opcode in instruction[31:26] that stops fetch.

Ports:
- clk  input  1  system clock; all state updates on falling edge, matching existing PC timing.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  one-cycle pulse; begin or restart execution from PC 0.
- run_mode  input  1  0 = continuous, 1 = single-step; sampled on start.
- step  input  1  one-cycle pulse; advance one fetch in step mode.
- instruction  input  32  ROM output at current pc.
- stall  input  1  active-high hazard hold request.
- branch_taken  input  1  taken branch resolved downstream.
- branch_offset  input  PC_WIDTH  signed relative offset added to pc.
- pc  output  PC_WIDTH  ROM address, registered.
- if_valid  output  1  current instruction may be latched into IF/ID.
- flush  output  1  kill IF/ID contents this cycle.
- halted  output  1  HALT state indicator.
- cycle_count  output  16  number of advancing fetch edges since start, saturating.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, pc=0, if_valid=0, flush=0, halted=0, cycle_count=0.
  - Flush counter, step_pending and latched mode are cleared.
  - Reset mid-operation aborts everything; no partial PC update.
- States: IDLE, RUN, STEP_WAIT, HALT. Outputs are registered, updated on the falling edge.
- IDLE:
  - pc holds 0, if_valid=0.
  - start → pc=0, cycle_count=0, latch run_mode; go RUN (mode 0) or STEP_WAIT (mode 1).
  - step is ignored in IDLE; start wins if start and step coincide.
- Advance edge: every edge in RUN; in step mode, an edge with step_pending=1.
- Next-PC priority on an advance edge, highest first:
  - branch_taken → pc=pc+branch_offset (wraps); load flush counter with FLUSH_CYCLES.
  - stall → pc holds; step_pending is not consumed.
  - instruction[31:26]==HALT_OPCODE → pc holds; go HALT.
  - Opcode 6'h02 or 6'h03 (J/JAL) → pc=instruction[PC_WIDTH-1:0]; no flush.
  - Otherwise pc=pc+1; 2^PC_WIDTH-1 wraps to 0.
- Branch vs stall: branch_taken overrides stall on the same edge.
- Flush:
  - flush=1 and if_valid=0 while the flush counter is nonzero; the counter decrements each advance edge.
  - A new branch during flush reloads the counter.
- if_valid = 1 on cycles following an advance edge that was not a stall, is not in flush and is not halted. Otherwise 0.
- cycle_count:
  - Increments on each advance edge, including stalled ones; saturates at 16'hFFFF.
  - Frozen in IDLE, HALT and STEP_WAIT idle.
- Single step:
  - step sets step_pending in STEP_WAIT.
  - One advance occurs on the next edge; if_valid=1 for exactly one cycle, then returns to waiting.
  - A stalled step keeps step_pending=1 and retries on following edges.
  - branch_taken is sampled only on advance edges.
- HALT:
  - halted=1, if_valid=0, pc frozen at the halt instruction; branch, stall and step are ignored.
  - start → pc=0, cycle_count=0, halted=0; re-enter RUN or STEP_WAIT.

Test Plan:
- Reset=0 mid-RUN at pc=37 → pc=0, state IDLE, all outputs 0 immediately, without waiting for a clock edge.
- Sequential run:
  - Stimulus: start with run_mode=0; ROM holds NOPs at 0..4, J 0x3F0 at 5, HALT_OPCODE at 0x3F0.
  - Required: pc=0,1,2,3,4,5,0x3F0; halted=1; cycle_count=7; pc stays 0x3F0.
- Branch with flush:
  - Stimulus: in RUN at pc=10, branch_taken=1, offset=10'h3FC (-4), FLUSH_CYCLES=1.
  - Required: pc=6, flush=1 and if_valid=0 for one cycle, then pc=7 with if_valid=1.
- Stall:
  - Stimulus: stall=1 for 3 edges at pc=20, with branch_taken=1 and offset=3 on the 2nd edge.
  - Required: pc holds 20 on edge 1, pc=23 on edge 2, holds 23 on edge 3.
- Wrap-around: run at pc=0x3FF with plain instruction → pc=0x000, if_valid=1.
- Step mode:
  - Stimulus: start with run_mode=1, then two step pulses, the second coinciding with stall=1 for 2 edges.
  - Required: pc=1 after first step; pc reaches 2 only after stall drops; if_valid high exactly 2 cycles total; pc holds between steps.
